csa_mac_accumulator: RTL

- Consumer end of the Booth multiplier's carry-save interface.
- Takes one (csa_a, csa_b) pair per beat, resolves it into a 16-bit product, sign/zero-extends it and accumulates over a frame.
- Presents the frame total on a valid/ready output.
- Sits between the 8x8 Booth multiplier array and downstream filter/DSP logic in the FPGA datapath.

---
 rtl/csa_mac_accumulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csa_mac_accumulator.sv
// Carry-save resolve + frame accumulator with valid/ready result handshake.
// Optional clamp-on-overflow when CSA_MAC_SATURATE_EN is defined (wraps otherwise).
module csa_mac_accumulator #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      csa_a,
    input  logic [15:0]      csa_b,
    input  logic             signed_mode,
    input  logic             in_last,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e             state_q;
    logic               ready_en_q;
    logic               p1_valid_q;
    logic [15:0]        p1_prod_q;
    logic               p1_sgn_q;
    logic               p1_last_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [7:0]         cnt_q;

    logic               s2_go;
    logic               accept;
    logic               consume;
    logic               frame_open;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum_raw;
    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic               ovf_now;
    logic               ovf_next;
    logic [7:0]         cnt_base;
    logic [7:0]         cnt_next;

    always_comb begin
        s2_go      = ~(out_valid & ~out_ready);
        // ready_en_q keeps in_ready low while in reset and until the first edge after it
        in_ready   = ready_en_q & ~acc_clr & (~p1_valid_q | s2_go);
        accept     = in_valid & in_ready;
        consume    = p1_valid_q & s2_go;
        frame_open = (state_q == StAccum);

        ext = p1_sgn_q ? {{(ACC_W-16){p1_prod_q[15]}}, p1_prod_q}
                       : {{(ACC_W-16){1'b0}}, p1_prod_q};
        base = frame_open ? acc_q : '0;
        {carry, sum_raw} = {1'b0, base} + {1'b0, ext};

        if (p1_sgn_q) begin
            ovf_now = (base[ACC_W-1] == ext[ACC_W-1]) & (sum_raw[ACC_W-1] != base[ACC_W-1]);
        end else begin
            ovf_now = carry;
        end
        ovf_next = (frame_open & ovf_q) | ovf_now;

        sum = sum_raw;
`ifdef CSA_MAC_SATURATE_EN
        if (ovf_now) begin
            if (!p1_sgn_q) begin
                sum = '1;
            end else if (base[ACC_W-1]) begin
                sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
`endif

        cnt_base = frame_open ? cnt_q : 8'd0;
        cnt_next = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            p1_valid_q <= 1'b0;
            p1_prod_q  <= '0;
            p1_sgn_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            acc_out    <= '0;
            out_ovf    <= 1'b0;
            out_count  <= '0;
        end else begin
            ready_en_q <= 1'b1;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (state_q == StHold) begin
                    state_q <= StIdle;
                end
            end

            if (acc_clr) begin
                // Drops the open frame; a pending result keeps its handshake
                p1_valid_q <= 1'b0;
                acc_q      <= '0;
                ovf_q      <= 1'b0;
                cnt_q      <= '0;
                if (state_q == StAccum) begin
                    state_q <= StIdle;
                end
            end else begin
                if (accept) begin
                    p1_prod_q  <= csa_a + csa_b;
                    p1_sgn_q   <= signed_mode;
                    p1_last_q  <= in_last;
                    p1_valid_q <= 1'b1;
                end else if (consume) begin
                    p1_valid_q <= 1'b0;
                end

                if (consume) begin
                    if (p1_last_q) begin
                        acc_out   <= sum;
                        out_ovf   <= ovf_next;
                        out_count <= cnt_next;
                        out_valid <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        acc_q   <= sum;
                        ovf_q   <= ovf_next;
                        cnt_q   <= cnt_next;
                        state_q <= StAccum;
                    end
                end
            end
        end
    end

endmodule
